// File: rtl/pre_proc_hpf_if.sv
// ---------------------------------------------------------------------------
// pre_proc_hpf_if
//   Sample-stream bundle for the pre_proc_hpf block.
//
//   Handshake: an input sample transfers on a rising clk edge where
//   in_valid && in_ready are both high. The source holds in_valid, in_ch and
//   audio_in stable until that edge. in_ready never depends on in_valid.
//   The output side has no back-pressure: out_valid is a one-cycle pulse
//   carrying out_ch/pre_proc_audio, and the consumer must take it.
//
//   Parameters: DW  sample width, CHW channel-id width.
//   Signals:
//     in_valid / in_ready / in_ch / audio_in    input sample stream
//     out_valid / out_ch / pre_proc_audio       filtered result
//   Modports: master = sample source/result sink, slave = the filter.
// ---------------------------------------------------------------------------
interface pre_proc_hpf_if #(
  parameter int DW  = 16,
  parameter int CHW = 1
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [CHW-1:0]        in_ch;
  logic signed [DW-1:0]  audio_in;
  logic                  out_valid;
  logic [CHW-1:0]        out_ch;
  logic signed [DW-1:0]  pre_proc_audio;

  modport master (
    output in_valid, in_ch, audio_in,
    input  in_ready, out_valid, out_ch, pre_proc_audio
  );

  modport slave (
    input  in_valid, in_ch, audio_in,
    output in_ready, out_valid, out_ch, pre_proc_audio
  );
endinterface

// File: rtl/pre_proc_hpf.sv
// ---------------------------------------------------------------------------
// pre_proc_hpf
//   G.729-style input pre-processing: scale by 1/2 folded into a 2nd-order
//   140 Hz high-pass IIR, time-multiplexed over NCH channels with one shared
//   16x32 multiplier. One sample takes 7 enabled cycles (IDLE, 5x MAC, OUT).
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     ce           clock enable; low freezes everything, in_ready/out_valid 0
//     clr          synchronous clear of all channel histories, aborts sample
//     bus          pre_proc_hpf_if.slave sample in / result out
//     state_dbg    current FSM state (IDLE=0, MAC=1, OUT=2)
//     sat_cnt      output saturation event counter, present only when
//                  PRE_PROC_HPF_SAT_CNT_EN is defined
//
//   Number formats: coefficients Q12, y history Q16 (32-bit), accumulator
//   Q12 (40-bit). x operands are presented to the multiplier as x<<16.
// ---------------------------------------------------------------------------
module pre_proc_hpf #(
  parameter int DW  = 16,
  parameter int NCH = 1,
  parameter int CHW = 1,
  parameter int B0  = 1899,
  parameter int B1  = -3798,
  parameter int B2  = 1899,
  parameter int A1  = 7807,
  parameter int A2  = -3733
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          clr,
  pre_proc_hpf_if.slave bus,
  output logic [1:0]    state_dbg
`ifdef PRE_PROC_HPF_SAT_CNT_EN
  ,
  output logic [15:0]   sat_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  localparam logic signed [15:0] C_B0 = 16'(B0);
  localparam logic signed [15:0] C_B1 = 16'(B1);
  localparam logic signed [15:0] C_B2 = 16'(B2);
  localparam logic signed [15:0] C_A1 = 16'(A1);
  localparam logic signed [15:0] C_A2 = 16'(A2);

  localparam logic signed [39:0] OUT_MAX = (40'sd1 <<< (DW - 1)) - 40'sd1;
  localparam logic signed [39:0] OUT_MIN = -(40'sd1 <<< (DW - 1));
  localparam logic signed [43:0] Y_MAX   = 44'sd2147483647;
  localparam logic signed [43:0] Y_MIN   = -44'sd2147483648;

  state_t state, state_n;

  // Per-channel filter history
  logic signed [DW-1:0] x1_mem [NCH];
  logic signed [DW-1:0] x2_mem [NCH];
  logic signed [31:0]   y1_mem [NCH];
  logic signed [31:0]   y2_mem [NCH];

  // Working copy of the sample in flight
  logic signed [DW-1:0] x0_q, hx1_q, hx2_q;
  logic signed [31:0]   hy1_q, hy2_q;
  logic [CHW-1:0]       ch_q;
  logic [2:0]           tap_q;
  logic signed [39:0]   acc_q;

  logic                 out_valid_q;
  logic [CHW-1:0]       out_ch_q;
  logic signed [DW-1:0] out_audio_q;

  logic                 ready, accept, ch_ok;
  logic signed [DW-1:0] rd_x1, rd_x2;
  logic signed [31:0]   rd_y1, rd_y2;

  logic signed [15:0]   coef;
  logic signed [31:0]   opnd;
  logic signed [47:0]   prod;
  logic signed [31:0]   prod_q12;
  logic signed [39:0]   rnd, out_full;
  logic                 out_hi, out_lo;
  logic signed [DW-1:0] out_sat_val;
  logic signed [43:0]   y_full;
  logic signed [31:0]   y_new;

  function automatic logic signed [31:0] x_q16(input logic signed [DW-1:0] x);
    logic signed [31:0] t;
    t = 32'(x);
    return t <<< 16;
  endfunction

  // History lookup for the channel being offered; also flags a legal id.
  always_comb begin
    ch_ok = 1'b0;
    rd_x1 = '0;
    rd_x2 = '0;
    rd_y1 = '0;
    rd_y2 = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.in_ch == CHW'(i)) begin
        ch_ok = 1'b1;
        rd_x1 = x1_mem[i];
        rd_x2 = x2_mem[i];
        rd_y1 = y1_mem[i];
        rd_y2 = y2_mem[i];
      end
    end
  end

  // Reset is folded in so in_ready stays low while rst_n is asserted.
  assign ready  = ce && rst_n && (state == IDLE);
  // An out-of-range channel is still taken (ready high) but never started.
  assign accept = bus.in_valid && ready && ch_ok && !clr;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = MAC;
      MAC:     if (tap_q == 3'd4) state_n = OUT;
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clr) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (ce) state <= state_n;
  end

  // Tap order B0, B1, B2, A1, A2
  always_comb begin
    coef = C_B0;
    opnd = x_q16(x0_q);
    case (tap_q)
      3'd1:    begin coef = C_B1; opnd = x_q16(hx1_q); end
      3'd2:    begin coef = C_B2; opnd = x_q16(hx2_q); end
      3'd3:    begin coef = C_A1; opnd = hy1_q;        end
      3'd4:    begin coef = C_A2; opnd = hy2_q;        end
      default: ;
    endcase
  end

  assign prod     = 48'(coef) * 48'(opnd);
  assign prod_q12 = 32'(prod >>> 16);

  // Round-half-up to Q0 then clamp to the DW-bit range
  assign rnd         = acc_q + 40'sd2048;
  assign out_full    = rnd >>> 12;
  assign out_hi      = out_full > OUT_MAX;
  assign out_lo      = out_full < OUT_MIN;
  assign out_sat_val = out_hi ? OUT_MAX[DW-1:0] :
                       out_lo ? OUT_MIN[DW-1:0] : out_full[DW-1:0];

  // Q12 accumulator -> Q16 y state, clamped to 32 bits
  assign y_full = {acc_q, 4'b0000};
  assign y_new  = (y_full > Y_MAX) ? Y_MAX[31:0] :
                  (y_full < Y_MIN) ? Y_MIN[31:0] : y_full[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        x1_mem[i] <= '0;
        x2_mem[i] <= '0;
        y1_mem[i] <= '0;
        y2_mem[i] <= '0;
      end
      x0_q        <= '0;
      hx1_q       <= '0;
      hx2_q       <= '0;
      hy1_q       <= '0;
      hy2_q       <= '0;
      ch_q        <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_audio_q <= '0;
    end else if (ce) begin
      out_valid_q <= 1'b0;
      if (clr) begin
        for (int i = 0; i < NCH; i++) begin
          x1_mem[i] <= '0;
          x2_mem[i] <= '0;
          y1_mem[i] <= '0;
          y2_mem[i] <= '0;
        end
        acc_q <= '0;
        tap_q <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            x0_q  <= bus.audio_in;
            ch_q  <= bus.in_ch;
            hx1_q <= rd_x1;
            hx2_q <= rd_x2;
            hy1_q <= rd_y1;
            hy2_q <= rd_y2;
            acc_q <= '0;
            tap_q <= '0;
          end
          MAC: begin
            acc_q <= acc_q + 40'(prod_q12);
            tap_q <= tap_q + 3'd1;
          end
          OUT: begin
            for (int i = 0; i < NCH; i++) begin
              if (ch_q == CHW'(i)) begin
                x2_mem[i] <= hx1_q;
                x1_mem[i] <= x0_q;
                y2_mem[i] <= hy1_q;
                y1_mem[i] <= y_new;
              end
            end
            out_audio_q <= out_sat_val;
            out_ch_q    <= ch_q;
            out_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PRE_PROC_HPF_SAT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt <= '0;
    else if (ce) begin
      if (clr) sat_cnt <= '0;
      else if (state == OUT && !clr && (out_hi || out_lo) && sat_cnt != 16'hFFFF)
        sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

  // A pulse registered while ce is low is held and shows once ce returns.
  assign bus.in_ready       = ready;
  assign bus.out_valid      = out_valid_q && ce;
  assign bus.out_ch         = out_ch_q;
  assign bus.pre_proc_audio = out_audio_q;
  assign state_dbg          = state;

endmodule

// File: tb/tb_pre_proc_hpf.sv
// ---------------------------------------------------------------------------
// tb_pre_proc_hpf
//   Bench for pre_proc_hpf. u_dut: default coefficients, 3 channels (2-bit
//   channel id, so id 3 is out of range). u_sat: B0=16384, other taps 0.
//   A reference model of the difference equation predicts each result; the
//   expected value, channel and output cycle are queued when a sample is
//   accepted and compared when out_valid pulses.
// ---------------------------------------------------------------------------
module tb_pre_proc_hpf;

  localparam longint K_B0 = 1899;
  localparam longint K_B1 = -3798;
  localparam longint K_B2 = 1899;
  localparam longint K_A1 = 7807;
  localparam longint K_A2 = -3733;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n, ce, clr;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pre_proc_hpf_if #(.DW(16), .CHW(2)) m_if ();
  pre_proc_hpf_if #(.DW(16), .CHW(1)) s_if ();
  logic [1:0] m_state, s_state;
`ifdef PRE_PROC_HPF_SAT_CNT_EN
  logic [15:0] m_sat_cnt, s_sat_cnt;
`endif

  pre_proc_hpf #(.DW(16), .NCH(3), .CHW(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .clr       (clr),
    .bus       (m_if),
    .state_dbg (m_state)
`ifdef PRE_PROC_HPF_SAT_CNT_EN
    ,
    .sat_cnt   (m_sat_cnt)
`endif
  );

  pre_proc_hpf #(.DW(16), .NCH(1), .CHW(1), .B0(16384), .B1(0), .B2(0),
                 .A1(0), .A2(0)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .clr       (clr),
    .bus       (s_if),
    .state_dbg (s_state)
`ifdef PRE_PROC_HPF_SAT_CNT_EN
    ,
    .sat_cnt   (s_sat_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;
  logic signed [63:0] exp_q[$];
  int                 exp_ch_q[$];
  int                 exp_cyc_q[$];
  longint             last_out [3];

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint mx1 [3], mx2 [3], my1 [3], my2 [3];

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
  endfunction

  function automatic longint model_step(input int ch, input longint x);
    longint acc, o, yn;
    acc = K_B0 * x + K_B1 * mx1[ch] + K_B2 * mx2[ch]
        + ((K_A1 * my1[ch]) >>> 16) + ((K_A2 * my2[ch]) >>> 16);
    o = (acc + 2048) >>> 12;
    if (o > 32767) o = 32767;
    if (o < -32768) o = -32768;
    yn = acc <<< 4;
    if (yn > 64'sd2147483647) yn = 64'sd2147483647;
    if (yn < -64'sd2147483648) yn = -64'sd2147483648;
    mx2[ch] = mx1[ch]; mx1[ch] = x;
    my2[ch] = my1[ch]; my1[ch] = yn;
    return o;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (m_if.out_valid === 1'b1) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        chk("data", m_if.pre_proc_audio, exp_q.pop_front());
        chk("out_ch", m_if.out_ch, exp_ch_q.pop_front());
        chk("latency", cyc, exp_cyc_q.pop_front());
        last_out[m_if.out_ch % 3] = m_if.pre_proc_audio;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int ch, input int x, input int extra,
                      input bit push, output int acc_cyc);
    int g;
    @(negedge clk);
    m_if.in_valid = 1'b1;
    m_if.in_ch    = 2'(ch);
    m_if.audio_in = 16'(x);
    g = 0;
    while (m_if.in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    acc_cyc = cyc;
    chk("accept", m_if.in_ready, 1);
    if (m_if.in_ready === 1'b1 && push) begin
      exp_q.push_back(model_step(ch, x));
      exp_ch_q.push_back(ch);
      exp_cyc_q.push_back(cyc + 7 + extra);
    end
    @(posedge clk);
    #1;
    m_if.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  task automatic sat_xfer(input int x, input int exp);
    int g;
    @(negedge clk);
    s_if.in_valid = 1'b1;
    s_if.in_ch    = 1'b0;
    s_if.audio_in = 16'(x);
    g = 0;
    while (s_if.in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("sat_accept", s_if.in_ready, 1);
    @(posedge clk);
    #1;
    s_if.in_valid = 1'b0;
    g = 0;
    while (s_if.out_valid !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("sat_latency", g, 7);
    chk("sat_out", s_if.pre_proc_audio, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, prev, oc;
    rst_n = 1'b0;
    ce    = 1'b1;
    clr   = 1'b0;
    m_if.in_valid = 1'b0; m_if.in_ch = '0; m_if.audio_in = '0;
    s_if.in_valid = 1'b0; s_if.in_ch = '0; s_if.audio_in = '0;
    for (int i = 0; i < 3; i++) last_out[i] = 0;
    model_clear();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", m_if.in_ready, 0);
    chk("rst_out_valid", m_if.out_valid, 0);
    chk("rst_out_ch", m_if.out_ch, 0);
    chk("rst_audio", m_if.pre_proc_audio, 0);
    chk("rst_state", m_state, 0);
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready", m_if.in_ready, 1);

    // impulse on ch0, with ready gap after the first accept
    send(0, 4096, 0, 1, n);
    repeat (6) begin
      @(negedge clk);
      chk("ready_busy", m_if.in_ready, 0);
    end
    @(negedge clk);
    chk("ready_back", m_if.in_ready, 1);
    wait_drain();
    chk("imp_first", last_out[0], 1899);
    send(0, 0, 0, 1, n);
    wait_drain();
    chk("imp_second", last_out[0], -178);
    send(0, 0, 0, 1, n);
    wait_drain();

    // channel isolation: ch0 impulse interleaved with ch1 zeros
    pulse_clr();
    send(0, 4096, 0, 1, n);
    send(1, 0, 0, 1, n);
    send(0, 0, 0, 1, n);
    send(1, 0, 0, 1, n);
    wait_drain();
    chk("iso_ch0", last_out[0], -178);
    chk("iso_ch1", last_out[1], 0);

    // out-of-range channel: taken, no output, no history touched
    oc = out_cnt;
    send(3, 5000, 0, 0, n);
    @(negedge clk);
    chk("disc_ready", m_if.in_ready, 1);
    repeat (10) @(negedge clk);
    chk("disc_no_out", out_cnt - oc, 0);
    send(0, 1234, 0, 1, n);
    wait_drain();

    // ce low while idle forces in_ready low
    @(negedge clk);
    ce = 1'b0;
    #1 chk("ce_ready", m_if.in_ready, 0);
    @(negedge clk);
    ce = 1'b1;

    // ce dropped 5 cycles mid-MAC shifts the result by 5
    pulse_clr();
    send(0, 4096, 5, 1, n);
    @(negedge clk);
    ce = 1'b0;
    repeat (5) @(negedge clk);
    ce = 1'b1;
    wait_drain();
    chk("ce_result", last_out[0], 1899);

    // clr mid-MAC aborts the sample
    oc = out_cnt;
    send(0, 4096, 0, 0, n);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    repeat (10) @(negedge clk);
    chk("clr_no_out", out_cnt - oc, 0);
    send(0, 4096, 0, 1, n);
    wait_drain();
    chk("clr_after", last_out[0], 1899);

    // DC rejection on ch1, back-to-back samples
    pulse_clr();
    send(1, 1000, 0, 1, prev);
    wait_drain();
    chk("dc_first", last_out[1], 464);
    send(1, 1000, 0, 1, prev);
    for (int k = 2; k < 400; k++) begin
      send(1, 1000, 0, 1, n);
      chk("throughput", n - prev, 7);
      prev = n;
    end
    wait_drain();
    chk("dc_final_small", (last_out[1] <= 1 && last_out[1] >= -1), 1);

    // saturation instance
    sat_xfer(10000, 32767);
    sat_xfer(-10000, -32768);
    sat_xfer(5000, 20000);
`ifdef PRE_PROC_HPF_SAT_CNT_EN
    chk("sat_cnt", s_sat_cnt, 2);
`endif

    // asynchronous reset mid-MAC
    oc = out_cnt;
    send(0, 4096, 0, 0, n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", m_if.out_valid, 0);
    chk("arst_in_ready", m_if.in_ready, 0);
    chk("arst_state", m_state, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_clear();
    #1 chk("arst_rel_ready", m_if.in_ready, 1);
    repeat (8) @(negedge clk);
    chk("arst_no_out", out_cnt - oc, 0);
    send(0, 4096, 0, 1, n);
    wait_drain();
    chk("arst_after", last_out[0], 1899);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pre_proc_hpf.md
Name: pre_proc_hpf

Overview:
- Parametrised successor to the fixed-offset pre-processor: G.729-style input pre-processing, i.e. scale by 1/2 folded into a 2nd-order 140 Hz high-pass IIR.
- Multi-channel, time-multiplexed over one shared multiplier with a valid/ready input handshake.
- Sits between the audio capture path and LPC analysis.

Parameters:
- DW, 16: sample width (signed two's complement).
- NCH, 1: number of channels; each channel has independent filter history.
- CHW, 1: channel-id width; must satisfy 2^CHW >= NCH.
- B0, 1899: numerator coefficient, signed Q12.
- B1, -3798: numerator coefficient, signed Q12.
- B2, 1899: numerator coefficient, signed Q12.
- A1, 7807: feedback coefficient, signed Q12.
- A2, -3733: feedback coefficient, signed Q12.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; low freezes all state, outputs hold
- clr  in  1  synchronous clear of all channel histories
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_ch  in  CHW  channel of input sample
- audio_in  in  DW  input sample
- out_valid  out  1  one-cycle pulse, result valid
- out_ch  out  CHW  channel of result
- pre_proc_audio  out  DW  filtered sample

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: in_ready=0 during reset, 1 in the first cycle after release. out_valid=0, out_ch=0, pre_proc_audio=0. FSM goes to IDLE. All channel histories (x1, x2, y1, y2) are cleared.
- Per-channel history:
  - x1, x2: DW-bit.
  - y1, y2: 32-bit signed, Q16, i.e. value * 65536.
- Difference equation: y[n] = B0·x[n] + B1·x[n-1] + B2·x[n-2] + A1·y[n-1] + A2·y[n-2].
- Arithmetic:
  - One signed 16x32 multiplier.
  - For b taps the operand is x<<16. For a taps the operand is y (Q16).
  - Each product is arithmetically shifted right by 16, giving Q12, and added into a 40-bit accumulator.
  - Output = (acc+2048)>>>12, saturated to [-2^(DW-1), 2^(DW-1)-1].
  - New y = acc<<4, saturated to 32 bits.
- FSM (all transitions gated by ce):
  - IDLE: in_ready=1. On in_valid&in_ready, latch the sample and channel, load that channel's history, clear acc, go to MAC with tap=0.
  - MAC: one tap per cycle in order B0, B1, B2, A1, A2. After tap 4, go to OUT.
  - OUT: write back x2<=x1, x1<=x[n], y2<=y1, y1<=new y. Register pre_proc_audio and out_ch. Pulse out_valid for one cycle. Return to IDLE.
- Latency and throughput:
  - Accept edge T → out_valid high in the cycle after edge T+6.
  - Throughput is one sample per 7 enabled cycles. in_ready=0 outside IDLE.
- ce=0:
  - No state, counter or history changes.
  - in_ready is forced 0.
  - out_valid is forced 0; a pending pulse is emitted when ce returns.
- clr:
  - Zeroes every channel history and aborts any in-flight sample (no out_valid), returning to IDLE.
  - clr takes priority over a simultaneous accept; that sample is dropped.
- in_ch >= NCH: sample is accepted and discarded, with no output and no history change.
- Reset mid-operation: the computation is lost, no out_valid, all histories cleared.
- out_valid does not wait on downstream; the consumer must take it.

Optional Feature:
- Macro PRE_PROC_HPF_SAT_CNT_EN.
- When defined:
  - Adds output port sat_cnt, 16 bits.
  - It counts output saturation events, holding at 16'hFFFF.
  - It is cleared by rst_n and clr, and frozen by ce=0.
  - y-state saturation does not count.
- When undefined: no port and no counter logic. Behaviour is otherwise identical.

Test Plan:
- Impulse, default coefficients, NCH=1, after reset: feed 4096, then 0, 0 → outputs 1899, then -178; each out_valid exactly 7 cycles after accept; in_ready low for 6 cycles after each accept.
- DC rejection: constant 1000 for 400 samples → first output 464; |output| <= 1 by the final sample.
- Saturation with B0=16384, other coefficients 0: inputs 10000, -10000, 5000 → 32767, -32768, 20000; sat_cnt=2 when the macro is defined.
- Channel isolation, NCH=2: interleave ch0 impulse (4096, 0) with ch1 zeros → ch0 gives 1899, -178; ch1 gives 0, 0; out_ch tags match the inputs.
- ce/clr: drop ce for 5 cycles mid-MAC → result and timing shifted by exactly 5 cycles. Assert clr mid-MAC → no out_valid; next 4096 input yields 1899.
- Async reset mid-MAC: assert rst_n low between clock edges → out_valid=0 immediately; after release in_ready=1; impulse gives 1899.
